// File: rtl/dl_pkg.sv
// Shared types for the download-to-SDRAM writer: address/FIFO sizing,
// arbiter state encoding and the buffered download entry.
package dl_pkg;

    localparam int DL_ADDR_W     = 25;
    localparam int DL_FIFO_DEPTH = 8;

    typedef enum logic [1:0] {
        IDLE,
        DL_REQ,
        CPU_REQ,
        GAP
    } dl_state_t;

    typedef struct packed {
        logic [DL_ADDR_W-1:0] addr;
        logic [7:0]           data;
    } dl_entry_t;

endpackage

// File: rtl/dl_wr_fifo.sv
// Small synchronous write buffer for download bytes. A push into a full
// FIFO is accepted only when the head is being popped in the same cycle.
module dl_wr_fifo
    import dl_pkg::*;
#(
    parameter int DEPTH = DL_FIFO_DEPTH
) (
    input  logic      clk,
    input  logic      reset,
    input  logic      push,
    input  dl_entry_t push_entry,
    input  logic      pop,
    output logic      full,
    output logic      empty,
    output dl_entry_t head
);

    localparam int PTR_W = $clog2(DEPTH);

    dl_entry_t        mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (PTR_W+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_entry;
    end

endmodule

// File: rtl/dl_sdram_writer.sv
// Buffers download byte writes into SDRAM, arbitrates the controller with
// the CPU byte port and issues a CPU reset once a download has drained.
module dl_sdram_writer
    import dl_pkg::*;
#(
    parameter int FIFO_DEPTH = DL_FIFO_DEPTH,
    parameter int ADDR_W     = DL_ADDR_W,
    parameter int RESET_HOLD = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              dl_active,
    input  logic              dl_wr,
    input  logic [ADDR_W-1:0] dl_addr,
    input  logic [7:0]        dl_data,
    input  logic              cpu_rd,
    input  logic              cpu_wr,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [7:0]        cpu_din,
    output logic [7:0]        cpu_dout,
    output logic              cpu_wait,
    output logic              cpu_reset,
    output logic              ram_req,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [7:0]        ram_din,
    input  logic [7:0]        ram_dout,
    input  logic              ram_ack,
    output logic              overflow
);

    localparam int HOLD_W = $clog2(RESET_HOLD + 1);

    dl_state_t         state;
    dl_entry_t         push_entry;
    dl_entry_t         fifo_head;
    logic              fifo_full;
    logic              fifo_empty;
    logic              fifo_pop;
    logic              dl_drop;
    logic              dl_active_q;
    logic              dl_rise;
    logic              dl_fall;
    logic              armed;
    logic [HOLD_W-1:0] hold_cnt;
    logic              pend_valid;
    logic              pend_we;
    logic [ADDR_W-1:0] pend_addr;
    logic [7:0]        pend_din;
    logic              cpu_blocked;
    logic              launch_dl;
    logic              launch_cpu;

    assign push_entry  = '{addr: DL_ADDR_W'(dl_addr), data: dl_data};
    assign fifo_pop    = (state == DL_REQ) && ram_ack;
    assign dl_drop     = dl_wr && fifo_full && !fifo_pop;
    assign dl_rise     = dl_active && !dl_active_q;
    assign dl_fall     = !dl_active && dl_active_q;
    // The CPU stays off the bus from the end of a download until its reset pulse is over.
    assign cpu_blocked = dl_active || dl_fall || armed || cpu_reset;
    assign launch_dl   = !fifo_empty;
    assign launch_cpu  = pend_valid && !cpu_blocked;

    dl_wr_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (dl_wr),
        .push_entry(push_entry),
        .pop       (fifo_pop),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head      (fifo_head)
    );

    // GAP is the one-cycle request bubble; the next request may launch straight from it.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            ram_req    <= 1'b0;
            ram_we     <= 1'b0;
            ram_addr   <= '0;
            ram_din    <= '0;
            cpu_dout   <= '0;
            cpu_wait   <= 1'b0;
            pend_valid <= 1'b0;
            pend_we    <= 1'b0;
            pend_addr  <= '0;
            pend_din   <= '0;
        end else begin
            if (!pend_valid && (cpu_rd || cpu_wr)) begin
                pend_valid <= 1'b1;
                pend_we    <= cpu_wr;
                pend_addr  <= cpu_addr;
                pend_din   <= cpu_din;
                cpu_wait   <= 1'b1;
            end

            case (state)
                IDLE, GAP: begin
                    if (launch_dl) begin
                        state    <= DL_REQ;
                        ram_req  <= 1'b1;
                        ram_we   <= 1'b1;
                        ram_addr <= ADDR_W'(fifo_head.addr);
                        ram_din  <= fifo_head.data;
                    end else if (launch_cpu) begin
                        state    <= CPU_REQ;
                        ram_req  <= 1'b1;
                        ram_we   <= pend_we;
                        ram_addr <= pend_addr;
                        ram_din  <= pend_din;
                    end else begin
                        state    <= IDLE;
                    end
                end
                DL_REQ: begin
                    if (ram_ack) begin
                        state   <= GAP;
                        ram_req <= 1'b0;
                        ram_we  <= 1'b0;
                    end
                end
                CPU_REQ: begin
                    if (ram_ack) begin
                        state      <= GAP;
                        ram_req    <= 1'b0;
                        ram_we     <= 1'b0;
                        pend_valid <= 1'b0;
                        cpu_wait   <= 1'b0;
                        if (!pend_we) cpu_dout <= ram_dout;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // A new download cancels any pending or running post-download reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            dl_active_q <= 1'b0;
            armed       <= 1'b0;
            cpu_reset   <= 1'b0;
            hold_cnt    <= '0;
            overflow    <= 1'b0;
        end else begin
            dl_active_q <= dl_active;

            if (dl_rise)      overflow <= 1'b0;
            else if (dl_drop) overflow <= 1'b1;

            if (dl_rise) begin
                armed     <= 1'b0;
                cpu_reset <= 1'b0;
            end else if (cpu_reset) begin
                if (hold_cnt == '0) cpu_reset <= 1'b0;
                else                hold_cnt  <= hold_cnt - 1'b1;
            end else if (armed && fifo_empty && state == IDLE) begin
                armed     <= 1'b0;
                cpu_reset <= 1'b1;
                hold_cnt  <= HOLD_W'(RESET_HOLD - 1);
            end else if (dl_fall) begin
                armed     <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_dl_sdram_writer.sv
// Directed bench for dl_sdram_writer: a vector table for a download burst,
// then hand-written sequences for overflow, CPU stall/reset and reset abort.
module tb_dl_sdram_writer;

    logic        clk = 1'b0;
    logic        reset;
    logic        dl_active;
    logic        dl_wr;
    logic [24:0] dl_addr;
    logic [7:0]  dl_data;
    logic        cpu_rd;
    logic        cpu_wr;
    logic [24:0] cpu_addr;
    logic [7:0]  cpu_din;
    logic [7:0]  cpu_dout;
    logic        cpu_wait;
    logic        cpu_reset;
    logic        ram_req;
    logic        ram_we;
    logic [24:0] ram_addr;
    logic [7:0]  ram_din;
    logic [7:0]  ram_dout;
    logic        ram_ack;
    logic        overflow;

    int vectors    = 0;
    int miscompares = 0;

    typedef struct packed {
        logic        dl_active;
        logic        dl_wr;
        logic [24:0] dl_addr;
        logic [7:0]  dl_data;
        logic        ram_ack;
        logic        exp_req;
        logic        exp_we;
        logic [24:0] exp_addr;
        logic [7:0]  exp_din;
    } vec_t;

    vec_t tbl [15];

    always #5 clk = ~clk;

    dl_sdram_writer dut (
        .clk      (clk),
        .reset    (reset),
        .dl_active(dl_active),
        .dl_wr    (dl_wr),
        .dl_addr  (dl_addr),
        .dl_data  (dl_data),
        .cpu_rd   (cpu_rd),
        .cpu_wr   (cpu_wr),
        .cpu_addr (cpu_addr),
        .cpu_din  (cpu_din),
        .cpu_dout (cpu_dout),
        .cpu_wait (cpu_wait),
        .cpu_reset(cpu_reset),
        .ram_req  (ram_req),
        .ram_we   (ram_we),
        .ram_addr (ram_addr),
        .ram_din  (ram_din),
        .ram_dout (ram_dout),
        .ram_ack  (ram_ack),
        .overflow (overflow)
    );

    function automatic vec_t mk(input logic act, input logic wr, input logic [24:0] a,
                                input logic [7:0] d, input logic ack, input logic er,
                                input logic ew, input logic [24:0] ea, input logic [7:0] ed);
        vec_t v;
        v.dl_active = act; v.dl_wr = wr; v.dl_addr = a; v.dl_data = d; v.ram_ack = ack;
        v.exp_req = er; v.exp_we = ew; v.exp_addr = ea; v.exp_din = ed;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        dl_active = v.dl_active;
        dl_wr     = v.dl_wr;
        dl_addr   = v.dl_addr;
        dl_data   = v.dl_data;
        ram_ack   = v.ram_ack;
    endtask

    task automatic doReset();
        reset = 1'b1; dl_active = 0; dl_wr = 0; dl_addr = '0; dl_data = '0;
        cpu_rd = 0; cpu_wr = 0; cpu_addr = '0; cpu_din = '0; ram_ack = 0; ram_dout = '0;
        tick();
        reset = 1'b0;
    endtask

    task automatic waitReq(input string name, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (ram_req) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (!ok) checkOutput({name, "_req_timeout"}, 32'(ram_req), 1);
    endtask

    task automatic serviceReq(input string name, input logic exp_we, input logic [24:0] exp_addr,
                              input logic [7:0] exp_din, input bit check_din, input int hold,
                              input logic [7:0] dout);
        bit ok;
        waitReq(name, ok);
        if (ok) begin
            checkOutput({name, "_we"}, 32'(ram_we), 32'(exp_we));
            checkOutput({name, "_addr"}, 32'(ram_addr), 32'(exp_addr));
            if (check_din) checkOutput({name, "_din"}, 32'(ram_din), 32'(exp_din));
            for (int h = 0; h < hold; h++) begin
                tick();
                checkOutput({name, "_held_req"}, 32'(ram_req), 1);
                checkOutput({name, "_held_addr"}, 32'(ram_addr), 32'(exp_addr));
            end
            ram_ack = 1'b1; ram_dout = dout;
            tick();
            ram_ack = 1'b0; ram_dout = '0;
            checkOutput({name, "_req_drop"}, 32'(ram_req), 0);
        end
    endtask

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int hi;
        int reqs;
        bit ok;

        // Burst of three writes, ack after three request cycles, one-cycle gaps.
        tbl[0]  = mk(1, 1, 25'h000000, 8'hC3, 0, 0, 0, 25'h0, 8'h00);
        tbl[1]  = mk(1, 1, 25'h000001, 8'h12, 0, 1, 1, 25'h0, 8'hC3);
        tbl[2]  = mk(1, 1, 25'h000002, 8'h34, 0, 1, 1, 25'h0, 8'hC3);
        tbl[3]  = mk(1, 0, 25'h0, 8'h00, 0, 1, 1, 25'h0, 8'hC3);
        tbl[4]  = mk(1, 0, 25'h0, 8'h00, 1, 0, 0, 25'h0, 8'h00);
        tbl[5]  = mk(1, 0, 25'h0, 8'h00, 0, 1, 1, 25'h1, 8'h12);
        tbl[6]  = mk(1, 0, 25'h0, 8'h00, 0, 1, 1, 25'h1, 8'h12);
        tbl[7]  = mk(1, 0, 25'h0, 8'h00, 0, 1, 1, 25'h1, 8'h12);
        tbl[8]  = mk(1, 0, 25'h0, 8'h00, 1, 0, 0, 25'h0, 8'h00);
        tbl[9]  = mk(1, 0, 25'h0, 8'h00, 0, 1, 1, 25'h2, 8'h34);
        tbl[10] = mk(1, 0, 25'h0, 8'h00, 0, 1, 1, 25'h2, 8'h34);
        tbl[11] = mk(1, 0, 25'h0, 8'h00, 0, 1, 1, 25'h2, 8'h34);
        tbl[12] = mk(1, 0, 25'h0, 8'h00, 1, 0, 0, 25'h0, 8'h00);
        tbl[13] = mk(1, 0, 25'h0, 8'h00, 0, 0, 0, 25'h0, 8'h00);
        tbl[14] = mk(1, 0, 25'h0, 8'h00, 0, 0, 0, 25'h0, 8'h00);

        doReset();
        checkOutput("rst_ram_req", 32'(ram_req), 0);
        checkOutput("rst_ram_we", 32'(ram_we), 0);
        checkOutput("rst_ram_addr", 32'(ram_addr), 0);
        checkOutput("rst_ram_din", 32'(ram_din), 0);
        checkOutput("rst_cpu_dout", 32'(cpu_dout), 0);
        checkOutput("rst_cpu_wait", 32'(cpu_wait), 0);
        checkOutput("rst_cpu_reset", 32'(cpu_reset), 0);
        checkOutput("rst_overflow", 32'(overflow), 0);

        for (int i = 0; i < 15; i++) begin
            applyStimulus(tbl[i]);
            tick();
            checkOutput($sformatf("tbl%0d_req", i), 32'(ram_req), 32'(tbl[i].exp_req));
            if (tbl[i].exp_req) begin
                checkOutput($sformatf("tbl%0d_we", i), 32'(ram_we), 32'(tbl[i].exp_we));
                checkOutput($sformatf("tbl%0d_addr", i), 32'(ram_addr), 32'(tbl[i].exp_addr));
                checkOutput($sformatf("tbl%0d_din", i), 32'(ram_din), 32'(tbl[i].exp_din));
            end
        end
        dl_wr = 0; ram_ack = 0;
        checkOutput("tbl_overflow", 32'(overflow), 0);

        // Overflow: ten pushes with acks withheld, eight survive.
        doReset();
        dl_active = 1;
        for (int i = 0; i < 10; i++) begin
            dl_wr = 1; dl_addr = 25'(i); dl_data = 8'('h40 + i);
            tick();
            if (i == 7) checkOutput("ovf_after8", 32'(overflow), 0);
            if (i == 8) checkOutput("ovf_after9", 32'(overflow), 1);
        end
        dl_wr = 0;
        for (int i = 0; i < 8; i++)
            serviceReq($sformatf("ovf_drain%0d", i), 1'b1, 25'(i), 8'('h40 + i), 1'b1, 1, 8'h00);
        reqs = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (ram_req) reqs++;
        end
        checkOutput("ovf_extra_reqs", 32'(reqs), 0);
        checkOutput("ovf_sticky", 32'(overflow), 1);
        dl_active = 0; tick(); tick();
        dl_active = 1; tick();
        checkOutput("ovf_cleared_by_rise", 32'(overflow), 0);
        checkOutput("ovf_rise_cancels_reset", 32'(cpu_reset), 0);

        // CPU read during download, then drain, reset pulse and finally the read.
        doReset();
        dl_active = 1; tick();
        cpu_rd = 1; cpu_addr = 25'h000100; cpu_din = 8'h00;
        tick();
        cpu_rd = 0;
        checkOutput("cpu_wait_rise", 32'(cpu_wait), 1);
        reqs = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (ram_req) reqs++;
        end
        checkOutput("cpu_no_req_during_dl", 32'(reqs), 0);
        dl_wr = 1; dl_addr = 25'h10; dl_data = 8'hAA; tick();
        dl_wr = 1; dl_addr = 25'h11; dl_data = 8'hBB; tick();
        dl_wr = 0; dl_active = 0; tick();
        serviceReq("dl_q0", 1'b1, 25'h10, 8'hAA, 1'b1, 2, 8'h00);
        serviceReq("dl_q1", 1'b1, 25'h11, 8'hBB, 1'b1, 2, 8'h00);
        checkOutput("crst_in_gap", 32'(cpu_reset), 0);
        tick();
        checkOutput("crst_in_idle", 32'(cpu_reset), 0);
        tick();
        checkOutput("crst_rise", 32'(cpu_reset), 1);
        hi = 1; reqs = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (ram_req) reqs++;
            if (cpu_reset) hi++;
            else break;
        end
        checkOutput("crst_hold_len", 32'(hi), 16);
        checkOutput("crst_no_cpu_req", 32'(reqs), 0);
        checkOutput("crst_cpu_wait_held", 32'(cpu_wait), 1);
        serviceReq("cpu_read", 1'b0, 25'h000100, 8'h00, 1'b0, 1, 8'hA5);
        checkOutput("cpu_read_dout", 32'(cpu_dout), 'hA5);
        checkOutput("cpu_read_wait_clr", 32'(cpu_wait), 0);

        // Simultaneous read and write strobes act as a write.
        cpu_rd = 1; cpu_wr = 1; cpu_addr = 25'h000200; cpu_din = 8'h5A;
        tick();
        cpu_rd = 0; cpu_wr = 0;
        serviceReq("cpu_rdwr", 1'b1, 25'h000200, 8'h5A, 1'b1, 0, 8'h77);
        checkOutput("cpu_write_dout_kept", 32'(cpu_dout), 'hA5);
        checkOutput("cpu_write_wait_clr", 32'(cpu_wait), 0);

        // Full FIFO with a push landing on the popping ack.
        doReset();
        dl_active = 1;
        for (int i = 0; i < 8; i++) begin
            dl_wr = 1; dl_addr = 25'('h300 + i); dl_data = 8'('h80 + i);
            tick();
        end
        checkOutput("full_head_req", 32'(ram_req), 1);
        checkOutput("full_head_addr", 32'(ram_addr), 'h300);
        dl_wr = 1; dl_addr = 25'h3FF; dl_data = 8'h99; ram_ack = 1;
        tick();
        dl_wr = 0; ram_ack = 0;
        checkOutput("full_pushpop_ovf", 32'(overflow), 0);
        for (int i = 1; i < 8; i++)
            serviceReq($sformatf("full_drain%0d", i), 1'b1, 25'('h300 + i), 8'('h80 + i), 1'b1, 0, 8'h00);
        serviceReq("full_new_entry", 1'b1, 25'h3FF, 8'h99, 1'b1, 0, 8'h00);
        checkOutput("full_ovf_final", 32'(overflow), 0);

        // Reset in the middle of a download request; a late ack is ignored.
        doReset();
        dl_active = 1;
        cpu_rd = 1; cpu_addr = 25'h40; tick();
        cpu_rd = 0;
        dl_wr = 1; dl_addr = 25'h500; dl_data = 8'h11; tick();
        dl_wr = 0;
        waitReq("abort", ok);
        checkOutput("abort_wait_before", 32'(cpu_wait), 1);
        reset = 1; tick();
        reset = 0;
        checkOutput("abort_req", 32'(ram_req), 0);
        checkOutput("abort_addr", 32'(ram_addr), 0);
        checkOutput("abort_cpu_wait", 32'(cpu_wait), 0);
        ram_ack = 1; tick();
        ram_ack = 0;
        reqs = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (ram_req) reqs++;
        end
        checkOutput("abort_late_ack_idle", 32'(reqs), 0);
        dl_wr = 1; dl_addr = 25'h501; dl_data = 8'h22; tick();
        dl_wr = 0;
        serviceReq("abort_next", 1'b1, 25'h501, 8'h22, 1'b1, 1, 8'h00);
        reqs = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (ram_req) reqs++;
        end
        checkOutput("abort_fifo_empty", 32'(reqs), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/dl_sdram_writer.md
Name: dl_sdram_writer

Overview:
- Sits directly downstream of the ROM/file download port on the SDRAM side of the MiST core.
- Takes single-cycle byte-write strobes (address + data) and buffers them in a small FIFO.
- Drains the FIFO into the SDRAM controller over a req/ack handshake, sharing that controller with the CPU byte port.
- While a download is active the CPU is stalled. When it ends and the FIFO has drained, the block emits a CPU reset pulse so the loaded image starts cleanly.

Parameters:
- FIFO_DEPTH, 8, write-buffer entries (power of two, >=2).
- ADDR_W, 25, byte address width.
- RESET_HOLD, 16, cycles cpu_reset is held after a download completes (>=1).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high.
- dl_active  in  1  high while a download or erase is in progress.
- dl_wr  in  1  single-cycle write strobe from the download port.
- dl_addr  in  ADDR_W  byte address, valid with dl_wr.
- dl_data  in  8  byte data, valid with dl_wr.
- cpu_rd  in  1  single-cycle CPU read strobe.
- cpu_wr  in  1  single-cycle CPU write strobe.
- cpu_addr  in  ADDR_W  CPU byte address, valid with strobe.
- cpu_din  in  8  CPU write data, valid with strobe.
- cpu_dout  out  8  CPU read data.
- cpu_wait  out  1  CPU must hold/stall.
- cpu_reset  out  1  post-download CPU reset.
- ram_req  out  1  request to SDRAM controller.
- ram_we  out  1  1 = write, 0 = read.
- ram_addr  out  ADDR_W  request address.
- ram_din  out  8  write data to SDRAM.
- ram_dout  in  8  read data from SDRAM, valid with ram_ack.
- ram_ack  in  1  single-cycle completion from controller.
- overflow  out  1  sticky: a download byte was dropped.

Behaviour:
- Reset (synchronous) forces the following, regardless of any in-flight transaction:
  - FIFO empty; FSM to IDLE; pending CPU request cleared.
  - ram_req=0, ram_we=0, ram_addr=0, ram_din=0.
  - cpu_dout=0, cpu_wait=0, cpu_reset=0, overflow=0.
  - A ram_ack arriving after reset is ignored.
- FIFO:
  - dl_wr pushes {dl_addr, dl_data} at the same edge.
  - Push when full with no pop in that cycle: byte dropped, overflow<=1.
  - Push when full with a pop in the same cycle: accepted.
  - Pop and push on an empty FIFO: a push to an empty FIFO becomes visible to the FSM the next cycle (no fall-through).
  - Pointers wrap modulo FIFO_DEPTH; count is one bit wider than the pointers.
- overflow clears on reset or on a rising edge of dl_active.
- CPU capture:
  - A cpu_rd or cpu_wr pulse latches addr, din and direction into a pending slot.
  - cpu_wait=1 from the cycle after the pulse until the cycle after the matching ram_ack, inclusive.
  - Strobes arriving while a request is pending are ignored.
  - Simultaneous rd+wr is treated as a write.
- FSM, states IDLE, DL_REQ, CPU_REQ, GAP:
  - IDLE -> DL_REQ if the FIFO is non-empty: present the head entry with ram_we=1 and ram_req=1 from the next cycle.
  - Else IDLE -> CPU_REQ if a CPU request is pending, dl_active=0 and cpu_reset=0.
  - Download has strict priority over the CPU. No CPU access while dl_active=1, even if the FIFO is empty.
  - In DL_REQ and CPU_REQ, ram_req, ram_we, ram_addr and ram_din stay stable until ram_ack.
  - On ram_ack in DL_REQ: pop the FIFO.
  - On ram_ack in CPU_REQ: cpu_dout<=ram_dout for reads, unchanged for writes; clear the pending slot.
  - ram_ack in either REQ state -> GAP, with ram_req=0 for exactly one cycle, then GAP -> IDLE.
  - Minimum spacing between successive requests is therefore 2 cycles after each ack.
  - ram_ack in IDLE or GAP is ignored.
- Post-download reset:
  - Arm on a falling edge of dl_active.
  - Once armed, the FIFO is empty and the FSM is in IDLE: cpu_reset=1 for exactly RESET_HOLD cycles, then 0.
  - A rising edge of dl_active while armed or counting cancels it: cpu_reset=0 and the arm is cleared.
  - The CPU is not serviced while cpu_reset=1.

Decomposition:
- Shared package dl_pkg holds:
  - localparams DL_ADDR_W=25 and DL_FIFO_DEPTH=8;
  - the FSM state enum {IDLE, DL_REQ, CPU_REQ, GAP};
  - the FIFO entry struct {addr[24:0], data[7:0]}.
- One sub-module, dl_wr_fifo: a synchronous FIFO with push, pop, full, empty, head and the same-cycle push/pop-when-full rule.
- The FSM, CPU slot and reset timer live in the top level.

Test Plan:
- Burst of 3 dl_wr (0x000000/0xC3, 0x000001/0x12, 0x000002/0x34), ram_ack 3 cycles after each req -> three write requests in order, ram_req low exactly 1 cycle between them, FIFO empty after the third ack.
- 10 back-to-back dl_wr with ram_ack withheld -> first 8 accepted, bytes 9–10 dropped, overflow=1. Releasing acks drains exactly 8 entries; a rising dl_active clears overflow.
- cpu_rd addr 0x000100 while dl_active=1 -> cpu_wait=1 and no CPU req. After dl_active falls and the FIFO drains, the read is held until cpu_reset completes. Then a read req is issued; an ack with ram_dout=0xA5 gives cpu_dout=0xA5 and cpu_wait=0 the next cycle.
- dl_active falls with 2 entries queued -> cpu_reset rises only after the second ack's GAP and stays high 16 cycles.
- Full FIFO, dl_wr coincident with the ram_ack that pops -> new byte stored, overflow stays 0.
- Reset asserted while ram_req=1 in DL_REQ -> next cycle ram_req=0, FIFO empty, cpu_wait=0. A late ram_ack is ignored with no pop and no state change.
